// File: rtl/led_status_sched.sv
// led_status_sched: time-multiplexes one bicolour status LED across several ports,
// round-robin with flap priority, pre-emption and a flap blink.
module led_status_sched #(
    parameter int Ports      = 4,
    parameter int TickCycles = 1000000,
    parameter int ShowTicks  = 8,
    parameter int GapTicks   = 2,
    parameter int BlinkTicks = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [Ports-1:0]         link_up,
    input  logic [Ports-1:0]         activity,
    input  logic [Ports-1:0]         flap,
    output logic                     led_green,
    output logic                     led_red,
    output logic                     show_valid,
    output logic [$clog2(Ports)-1:0] cur_port
);
    localparam int PW = $clog2(Ports);
    localparam int TW = $clog2(TickCycles);
    localparam int SW = $clog2(ShowTicks + 1);
    localparam int GW = $clog2(GapTicks + 1);
    localparam int BW = $clog2(BlinkTicks + 1);

    typedef enum logic [1:0] {GAP, SHOW, NONE} state_t;

    state_t         state_q, state_d;
    logic [TW-1:0]  tc_q;
    logic [SW-1:0]  sc_q, sc_d;
    logic [GW-1:0]  gc_q, gc_d;
    logic [BW-1:0]  bc_q, bc_d;
    logic           ph_q, ph_d;
    logic [PW-1:0]  cur_q, cur_d, last_q, last_d, win_e, win_f, win;
    logic [Ports-1:0] acc_q, prev_q, elig, other_flap;
    logic           tick, found, preempt, led_g_q, led_r_q, g_d, r_d;

    function automatic logic [PW-1:0] scan(input logic [PW-1:0] base, input int i);
        return PW'((int'(base) + i) % Ports);
    endfunction

    assign tick       = tc_q == TW'(TickCycles - 1);
    assign elig       = link_up | flap;
    assign found      = |elig;
    assign other_flap = flap & ~(Ports'(1) << cur_q);
    assign preempt    = ~flap[cur_q] & (|other_flap);
    assign led_green  = led_g_q;
    assign led_red    = led_r_q;
    assign show_valid = state_q == SHOW;
    assign cur_port   = cur_q;

    // Walking the scan order backwards leaves the earliest match in scan order.
    always_comb begin
        win_e = '0;
        win_f = '0;
        for (int i = Ports; i >= 1; i--) begin
            if (elig[scan(last_q, i)]) win_e = scan(last_q, i);
            if (flap[scan(last_q, i)]) win_f = scan(last_q, i);
        end
        win = |flap ? win_f : win_e;
    end

    always_comb begin
        state_d = state_q;
        sc_d    = sc_q;
        gc_d    = gc_q;
        bc_d    = bc_q;
        ph_d    = ph_q;
        cur_d   = cur_q;
        last_d  = last_q;
        if (tick) begin
            case (state_q)
                GAP: begin
                    if (gc_q == GW'(GapTicks - 1)) begin
                        gc_d    = '0;
                        state_d = found ? SHOW : NONE;
                        if (found) begin
                            cur_d  = win;
                            last_d = win;
                            sc_d   = '0;
                            bc_d   = '0;
                            ph_d   = 1'b0;
                        end
                    end else begin
                        gc_d = gc_q + 1'b1;
                    end
                end
                SHOW: begin
                    state_d = (sc_q == SW'(ShowTicks - 1) || preempt) ? GAP : SHOW;
                    sc_d    = sc_q + 1'b1;
                    bc_d    = (bc_q == BW'(BlinkTicks - 1)) ? '0 : bc_q + 1'b1;
                    ph_d    = (bc_q == BW'(BlinkTicks - 1)) ? ~ph_q : ph_q;
                end
                NONE:    state_d = found ? GAP : NONE;
                default: state_d = GAP;
            endcase
        end
    end

    // LED drive follows the live inputs of the port on display.
    always_comb begin
        g_d = state_q == SHOW && !flap[cur_q] && link_up[cur_q] && !prev_q[cur_q];
        r_d = state_q == NONE || (state_q == SHOW && (flap[cur_q] ? ~ph_q : ~link_up[cur_q]));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= GAP;
            tc_q    <= '0;
            sc_q    <= '0;
            gc_q    <= '0;
            bc_q    <= '0;
            ph_q    <= 1'b0;
            cur_q   <= '0;
            last_q  <= PW'(Ports - 1);
            acc_q   <= '0;
            prev_q  <= '0;
            led_g_q <= 1'b0;
            led_r_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tc_q    <= tick ? '0 : tc_q + 1'b1;
            sc_q    <= sc_d;
            gc_q    <= gc_d;
            bc_q    <= bc_d;
            ph_q    <= ph_d;
            cur_q   <= cur_d;
            last_q  <= last_d;
            acc_q   <= tick ? '0 : acc_q | activity;
            prev_q  <= tick ? acc_q | activity : prev_q;
            led_g_q <= g_d;
            led_r_q <= r_d;
        end
    end
endmodule

// File: tb/tb_led_status_sched.sv
// tb_led_status_sched: randomized and directed stimulus checked cycle by cycle
// against a tick-level behavioural model of the LED scheduler.
module tb_led_status_sched;
    localparam int P = 4, TC = 4, ST = 3, GT = 1, BT = 1;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [P-1:0] link_up = '0, activity = '0, flap = '0;
    logic         led_green, led_red, show_valid;
    logic [1:0]   cur_port;

    led_status_sched #(
        .Ports(P), .TickCycles(TC), .ShowTicks(ST), .GapTicks(GT), .BlinkTicks(BT)
    ) dut (
        .clk(clk), .reset(reset), .link_up(link_up), .activity(activity), .flap(flap),
        .led_green(led_green), .led_red(led_red), .show_valid(show_valid), .cur_port(cur_port)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_bad = 0;

    // model: st 0=dark gap, 1=showing, 2=nothing eligible
    int           m_st, m_cyc, m_left, m_shown, m_last, m_cur;
    logic [P-1:0] m_acc, m_prev;
    bit           e_g, e_r;

    task automatic check(string tag, int got, int exp);
        n_chk++;
        if (got != exp) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic pick();
        int wf, we, p;
        wf = -1;
        we = -1;
        for (int k = 1; k <= P; k++) begin
            p = (m_last + k) % P;
            if (we < 0 && (link_up[p] || flap[p])) we = p;
            if (wf < 0 && flap[p]) wf = p;
        end
        if (wf >= 0) we = wf;
        if (we >= 0) begin
            m_st = 1;
            m_cur = we;
            m_last = we;
            m_shown = 0;
        end else begin
            m_st = 2;
        end
    endtask

    task automatic model_step();
        bit tk;
        if (reset) begin
            m_st = 0; m_cyc = 0; m_left = GT; m_shown = 0;
            m_last = P - 1; m_cur = 0; m_acc = '0; m_prev = '0;
            e_g = 0; e_r = 0;
        end else begin
            tk = (m_cyc == TC - 1);
            e_g = 0;
            e_r = 0;
            if (m_st == 2) e_r = 1;
            else if (m_st == 1) begin
                if (flap[m_cur]) e_r = ((m_shown / BT) % 2) == 0;
                else if (link_up[m_cur]) e_g = !m_prev[m_cur];
                else e_r = 1;
            end
            m_cyc = tk ? 0 : m_cyc + 1;
            if (tk) begin
                m_prev = m_acc | activity;
                m_acc = '0;
                if (m_st == 0) begin
                    m_left--;
                    if (m_left == 0) pick();
                end else if (m_st == 1) begin
                    m_shown++;
                    if (m_shown == ST || (!flap[m_cur] && (flap & ~(P'(1) << m_cur)) != 0)) begin
                        m_st = 0;
                        m_left = GT;
                    end
                end else if ((link_up | flap) != 0) begin
                    m_st = 0;
                    m_left = GT;
                end
            end else begin
                m_acc = m_acc | activity;
            end
        end
    endtask

    task automatic drive(int mode);
        reset = (mode == 0);
        activity = '0;
        case (mode)
            1: begin link_up = 4'b1111; flap = '0; end
            2: begin link_up = 4'b0100; flap = '0; end
            3: begin link_up = '0; flap = '0; end
            4: begin link_up = 4'b1111; flap = 4'b1000; end
            5: begin
                link_up = 4'b1111;
                if ($urandom_range(29) == 0) flap[2] = ~flap[2];
                if ($urandom_range(7) == 0) activity[$urandom_range(P - 1)] = 1'b1;
            end
            6: begin
                reset = ($urandom_range(249) == 0);
                if ($urandom_range(19) == 0) link_up = P'($urandom);
                for (int b = 0; b < P; b++) begin
                    if ($urandom_range(39) == 0) flap[b] = ~flap[b];
                    activity[b] = ($urandom_range(5) == 0);
                end
            end
            7: begin
                link_up = 4'b1111;
                flap = '0;
                activity[0] = ($urandom_range(9) == 0);
            end
            default: ;
        endcase
    endtask

    task automatic run(int n, int mode);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("led_green", int'(led_green), int'(e_g));
            check("led_red", int'(led_red), int'(e_r));
            check("show_valid", int'(show_valid), int'(m_st == 1));
            check("cur_port", int'(cur_port), m_cur);
            drive(mode);
            model_step();
        end
    endtask

    initial begin
        model_step();
        run(3, 0);
        run(90, 1);
        run(60, 2);
        run(40, 3);
        run(70, 4);
        run(120, 5);
        run(120, 7);
        run(1, 0);
        run(60, 1);
        run(2500, 6);
        run(2, 0);
        run(40, 1);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/led_status_sched.md
# led_status_sched

Time-multiplexes one bicolour front-panel status LED across `Ports` Fibre Channel ports. Per-port `link_up`, `activity` and `flap` inputs come from port status logic and from one `flap_detect` instance per port. The block sequences ports round-robin, gives flapping ports priority and pre-emption, and drives the LED pins plus a debug index of the port currently shown.

## Interface
- `Ports`, 4: number of requesters; 2..16.
- `TickCycles`, 1000000: `clk` cycles per display tick; must be ≥ 2.
- `ShowTicks`, 8: ticks a selected port is displayed; must be ≥ 1.
- `GapTicks`, 2: dark ticks between displays; must be ≥ 1.
- `BlinkTicks`, 1: half-period of the flap blink, in ticks; must be ≥ 1.

- `clk`, in, 1: sole clock.
- `reset`, in, 1: synchronous, active-high.
- `link_up`, in, `Ports`: per-port link state, level.
- `activity`, in, `Ports`: per-port single-cycle traffic pulses.
- `flap`, in, `Ports`: per-port flap flag, level, from `flap_detect`.
- `led_green`, out, 1: green LED drive, registered.
- `led_red`, out, 1: red LED drive, registered.
- `show_valid`, out, 1: high while in SHOW.
- `cur_port`, out, `$clog2(Ports)`: port being shown; holds its last value outside SHOW.

## Operation
- **Tick generator:** counter runs 0..`TickCycles-1`. `tick` pulses for one cycle when the count is `TickCycles-1`, then the counter wraps to 0. All FSM transitions and tick counters advance only on `tick`.
- **Activity latch:** `act_acc[p]` ORs in `activity[p]` every cycle. On `tick`, `act_prev <= act_acc | activity` and `act_acc` clears.
- **Eligibility:** port p is eligible when `link_up[p] | flap[p]`.
- **Selection,** evaluated on the GAP-exit tick:
  - Scan order is `last_port+1` upward, wrapping modulo `Ports`; `last_port` itself is scanned last.
  - The first eligible port with `flap` set wins.
  - If no eligible port has `flap` set, the first eligible port wins.
- **FSM states:** GAP, SHOW, NONE.
  - **GAP:** both LEDs off, `show_valid`=0. After `GapTicks` ticks, run selection. If a port is found: `cur_port`/`last_port` <= winner, go to SHOW. If none is found: go to NONE.
  - **SHOW:** lasts `ShowTicks` ticks, then GAP. At a tick boundary, SHOW is pre-empted straight to GAP when `flap[cur_port]`=0 and any other port has `flap`=1.
  - **NONE:** `led_red`=1, `led_green`=0. On each tick, if any port is eligible, go to GAP. Otherwise stay.
- **SHOW output, evaluated live every cycle from current inputs:**
  - `flap[cur]`=1: green off. Red is on for blink phase 0 and off for phase 1; the phase toggles every `BlinkTicks` ticks and resets to 0 on SHOW entry.
  - Else if `link_up[cur]`=1: red off. `led_green = ~act_prev[cur]`, i.e. green is dark for one tick after a tick that saw activity.
  - Else (the port lost eligibility mid-SHOW): red on, green off, until SHOW ends normally.
- **Arithmetic:** tick, show, gap and blink counters are sized with `$clog2` of their maximum value plus 1. Round-robin index wraps modulo `Ports`, with no out-of-range values.

## Timing
- **Reset values:** `led_green`=0, `led_red`=0, `show_valid`=0, `cur_port`=0. Internally: `last_port`=`Ports-1` (the first scan starts at port 0), state=GAP, tick counter, gap counter, show counter and blink phase all 0, `act_acc`=0, `act_prev`=0.
- **Reset mid-operation:** the block returns to exactly the reset state on the next edge. The first selection occurs `GapTicks*TickCycles` cycles after `reset` deasserts.
- **Output latency:** outputs are registered, so an FSM or input change appears on the LED pins one cycle later.
- **Simultaneous events:**
  - If the SHOW-expiry tick coincides with a pre-emption condition, there is a single transition to GAP.
  - A port that is both flapping and `last_port` is still eligible, but only after all other flapping ports in scan order.
- **Activity timing:** an `activity` pulse coincident with `tick` is counted in the tick that is ending.
- **Stable inputs:** with inputs held stable, the display period is `(GapTicks+ShowTicks)*TickCycles` cycles per port.

## Test plan
All scenarios use `Ports`=4, `TickCycles`=4, `ShowTicks`=3, `GapTicks`=1, `BlinkTicks`=1.

1. **Reset and first selection.** Release `reset` with `link_up`=4'b1111 and no flaps. Required: LEDs are off for 4 cycles, then SHOW runs for ports 0, 1, 2, 3, 0 in order. Each SHOW holds `led_green`=1 for 12 cycles and is separated by 4 dark cycles.
2. **Skipping and NONE.** Set `link_up`=4'b0100. Required: only port 2 is ever shown. Then clear `link_up` to 0. Required: after the current SHOW ends and one gap tick elapses, the block enters NONE with `led_red`=1 steady and `show_valid`=0.
3. **Flap priority.** Set `link_up`=4'b1111, `last_port`=0, `flap`=4'b1000. Required: the next selection picks port 3, not port 1. `led_red` toggles every 4 cycles starting on, and `led_green`=0.
4. **Pre-emption.** While port 1 is shown without a flap, raise `flap[2]`. Required: at the next tick the block goes to GAP, then shows port 2 flapping.
5. **Activity.** Pulse `activity[0]` once during tick n of port 0's SHOW. Required: `led_green`=0 for exactly tick n+1, then returns to 1.
6. **Reset mid-SHOW.** Assert `reset` for 1 cycle mid-SHOW. Required: all outputs are 0 on the next cycle, and port 0 is the first port shown afterwards.
